char_stream_tx: RTL
===================

Name: char_stream_tx

Overview:
- Producer side of the character-load interface on the POV display path.
- Holds a host-written message buffer of 7-bit ASCII characters.
- When the column scanner requests the next character slot, it emits one character as a single-cycle LoadChar strobe with Ascii valid.
- Sequences through the message and wraps so the text repeats each revolution.

Parameters:
DEPTH, 16, message buffer entries (power of 2)
AW, 4, buffer address width, log2(DEPTH)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
WrEn  in  1  host write strobe into message buffer
WrAddr  in  AW  host write address
WrData  in  7  host write data (ASCII)
MsgLen  in  AW+1  message length in chars; sampled on Start
Start  in  1  begin or restart streaming at index 0
Stop  in  1  halt streaming
CharReq  in  1  one-cycle request for next character from column scanner
LoadChar  out  1  one-cycle strobe: Ascii valid, consumer latches it
Ascii  out  7  character being delivered; held between strobes
Busy  out  1  high in any state other than IDLE
Wrap  out  1  one-cycle pulse coincident with LoadChar of the last char (index Len-1)
Index  out  AW  index of the next character to be emitted

Behaviour:
- Clock is Clock; Reset is synchronous, active-high. Reset values: LoadChar=0, Ascii=0, Busy=0, Wrap=0, Index=0, Len=0, Pend=0, FSM=IDLE. Buffer contents are not reset.
- All outputs are registered.
- Buffer: DEPTH x 7, one write port and one synchronous read port.
  - WrEn writes at any time, including while streaming.
  - Write and read of the same address in the same cycle returns the old data (read-before-write).
- Len latch on Start: Len = min(MsgLen, DEPTH). If Len=0, Start is ignored and the FSM stays IDLE.
- FSM states: IDLE, WAIT, FETCH, EMIT.
  - IDLE: Start with MsgLen!=0 -> WAIT, Index=0.
  - WAIT: CharReq or Pend -> FETCH; Pend cleared; buffer read issued at Index.
  - FETCH: read data returns -> EMIT.
  - EMIT: LoadChar=1 and Ascii=buffer[Index] for exactly one cycle. Index = (Index==Len-1) ? 0 : Index+1. Wrap=1 when Index==Len-1. Next state WAIT.
- Latency: CharReq sampled in WAIT -> LoadChar high 2 cycles later.
- CharReq during FETCH or EMIT sets Pend (depth 1). Further requests while Pend=1 are dropped. A pending request starts FETCH directly from WAIT, giving back-to-back characters every 3 cycles maximum.
- Stop:
  - In WAIT or FETCH: -> IDLE next cycle, no strobe emitted, Pend cleared.
  - In EMIT: the strobe in that cycle still completes, then -> IDLE.
  - Index is retained on Stop.
- Start while Busy: restart. Re-latch Len, Index=0, Pend=0, -> WAIT. An EMIT in progress still completes its strobe that cycle.
- Start and Stop in the same cycle: Stop wins.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and any LoadChar in flight is suppressed.
- Ascii holds its last emitted value between strobes and in IDLE.

Decomposition:
- Shared package:
  - ASCII width constant (7).
  - FSM state encoding (IDLE/WAIT/FETCH/EMIT).
  - Default DEPTH.
- Sub-module: char_msg_ram (DEPTH x 7, sync read, read-before-write). The FSM, index and pending logic stay in char_stream_tx.

Test Plan:
- Reset, then write "HI!" (0x48, 0x49, 0x21) at 0..2, MsgLen=3, Start, then 4 spaced CharReq pulses -> LoadChar 2 cycles after each request. Ascii sequence 0x48, 0x49, 0x21, 0x48. Wrap high only with 0x21.
- CharReq on 3 consecutive cycles from WAIT -> exactly 2 strobes (first request plus one pending), the third dropped. Strobe spacing is 3 cycles.
- MsgLen=0 with Start -> Busy stays 0 and no strobe. MsgLen=20 with DEPTH=16 -> Len=16, and Wrap occurs on the 16th strobe.
- Stop in the same cycle as EMIT -> that strobe occurs, then Busy=0. Stop during FETCH -> no strobe, IDLE next cycle.
- Host writes 0x5A to the address currently in FETCH -> the emitted char is the old value, and the next pass emits 0x5A.
- Reset asserted one cycle after CharReq -> no LoadChar, all outputs 0, Index=0. Start plus Stop in the same cycle from IDLE -> stays IDLE.

Source files
------------

// File: rtl/char_stream_tx_pkg.sv
// Shared types and constants for the POV character-load producer.
package char_stream_tx_pkg;

    localparam int unsigned ASCII_W       = 7;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_EMIT
    } state_t;

endpackage

// File: rtl/char_msg_ram.sv
// Message buffer: one write port, one synchronous read port, read-before-write.
module char_msg_ram
    import char_stream_tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = 4
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [ASCII_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [ASCII_W-1:0] o_rd_data
);

    logic [ASCII_W-1:0] r_mem [DEPTH];
    logic [ASCII_W-1:0] r_rd_data;

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/char_stream_tx.sv
// Streams the host-written message one character per scanner request, wrapping
// at the latched length so the text repeats every revolution.
module char_stream_tx
    import char_stream_tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               WrEn,
    input  logic [AW-1:0]      WrAddr,
    input  logic [ASCII_W-1:0] WrData,
    input  logic [AW:0]        MsgLen,
    input  logic               Start,
    input  logic               Stop,
    input  logic               CharReq,
    output logic               LoadChar,
    output logic [ASCII_W-1:0] Ascii,
    output logic               Busy,
    output logic               Wrap,
    output logic [AW-1:0]      Index
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t             r_state, w_next;
    logic [AW:0]        r_len, w_len_next, w_len_in;
    logic [AW-1:0]      r_index, w_idx_next;
    logic               r_pend, w_pend_next;
    logic               w_rd_en, w_load, w_start, w_last;
    logic [ASCII_W-1:0] w_rd_data;
    logic               r_load, r_wrap, r_busy;
    logic [ASCII_W-1:0] r_ascii;

    char_msg_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (Clock),
        .i_wr_en   (WrEn),
        .i_wr_addr (WrAddr),
        .i_wr_data (WrData),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_index),
        .o_rd_data (w_rd_data)
    );

    assign w_len_in = (MsgLen > DEPTH_L) ? DEPTH_L : MsgLen;
    assign w_start  = Start && !Stop && (MsgLen != '0);
    assign w_last   = ({1'b0, r_index} == (r_len - 1'b1));

    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        w_pend_next = r_pend;
        w_idx_next  = r_index;
        w_len_next  = r_len;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (Stop) begin
                    w_next      = S_IDLE;
                    w_pend_next = 1'b0;
                end else if (CharReq || r_pend) begin
                    w_next      = S_FETCH;
                    w_pend_next = 1'b0;
                    w_rd_en     = 1'b1;
                end
            end
            S_FETCH: begin
                if (Stop) begin
                    w_next      = S_IDLE;
                    w_pend_next = 1'b0;
                end else begin
                    w_next = S_EMIT;
                    w_load = 1'b1;
                    if (CharReq) w_pend_next = 1'b1;
                end
            end
            S_EMIT: begin
                w_idx_next = w_last ? '0 : r_index + 1'b1;
                if (Stop) begin
                    w_next      = S_IDLE;
                    w_pend_next = 1'b0;
                end else begin
                    w_next = S_WAIT;
                    if (CharReq) w_pend_next = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // A valid Start restarts from any state; the visible EMIT strobe is already registered.
        if (w_start) begin
            w_next      = S_WAIT;
            w_idx_next  = '0;
            w_pend_next = 1'b0;
            w_len_next  = w_len_in;
            w_rd_en     = 1'b0;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_load  <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
            r_ascii <= '0;
            r_index <= '0;
            r_len   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_load  <= w_load;
            r_wrap  <= w_load && w_last;
            r_busy  <= (w_next != S_IDLE);
            if (w_load) r_ascii <= w_rd_data;
            r_index <= w_idx_next;
            r_len   <= w_len_next;
            r_pend  <= w_pend_next;
        end
    end

    assign LoadChar = r_load;
    assign Ascii    = r_ascii;
    assign Busy     = r_busy;
    assign Wrap     = r_wrap;
    assign Index    = r_index;

endmodule
